// File: rtl/seq_calc_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_calc_unit
// Purpose  : Multi-cycle add/sub/mul/div unit with done/busy/err status.
//            Define SEQ_CALC_SIGNED_EN to honour signed_i (two's complement).
// Revision : 1.0 - initial release
// ============================================================================
module seq_calc_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [1:0]         fct_i,
    input  logic               signed_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [2*WIDTH-1:0] res_o,
    output logic [2*WIDTH-1:0] rem_o
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] F_ADD = 2'b00;
    localparam logic [1:0] F_SUB = 2'b01;
    localparam logic [1:0] F_MUL = 2'b10;
    localparam logic [1:0] F_DIV = 2'b11;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_fct;
    logic [CW-1:0]    r_cnt;
    logic [W2-1:0]    r_acc;
    logic [W2-1:0]    r_mcd;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rmd;
    logic [WIDTH-1:0] r_dvs;
    logic [W2-1:0]    r_res;
    logic [W2-1:0]    r_rem;
    logic             r_err;

    logic [W2-1:0]    w_a_ext;
    logic [W2-1:0]    w_b_ext;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [W2-1:0]    w_acc_nxt;
    logic [WIDTH:0]   w_sh;
    logic             w_qbit;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rmd_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [W2-1:0]    w_prod_fix;
    logic [W2-1:0]    w_quo_fix;
    logic [W2-1:0]    w_rem_fix;

    // One shift-add step of the magnitude product
    assign w_acc_nxt = r_q[0] ? (r_acc + r_mcd) : r_acc;

    // One restoring-division step; a successful trial subtract fits WIDTH bits
    assign w_sh      = {r_rmd, r_q[WIDTH-1]};
    assign w_qbit    = (w_sh >= {1'b0, r_dvs});
    assign w_diff    = w_sh[WIDTH-1:0] - r_dvs;
    assign w_rmd_nxt = w_qbit ? w_diff : w_sh[WIDTH-1:0];
    assign w_q_nxt   = {r_q[WIDTH-2:0], w_qbit};

`ifdef SEQ_CALC_SIGNED_EN
    logic r_sgn;
    logic w_neg_q;
    logic w_neg_r;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_sgn <= 1'b0;
        end else if (r_state == S_IDLE && start_i) begin
            r_sgn <= signed_i;
        end
    end

    assign w_a_ext    = r_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_b_ext    = r_sgn ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_a_mag    = (r_sgn && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_b_mag    = (r_sgn && r_b[WIDTH-1]) ? -r_b : r_b;
    // Operands stay held in r_a/r_b, so signs are re-derived at the last step
    assign w_neg_q    = r_sgn & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_neg_r    = r_sgn & r_a[WIDTH-1];
    assign w_prod_fix = w_neg_q ? -w_acc_nxt : w_acc_nxt;
    assign w_quo_fix  = w_neg_q ? -{{WIDTH{1'b0}}, w_q_nxt} : {{WIDTH{1'b0}}, w_q_nxt};
    assign w_rem_fix  = w_neg_r ? -{{WIDTH{1'b0}}, w_rmd_nxt} : {{WIDTH{1'b0}}, w_rmd_nxt};
`else
    logic w_unused_signed;

    assign w_unused_signed = signed_i;
    assign w_a_ext    = {{WIDTH{1'b0}}, r_a};
    assign w_b_ext    = {{WIDTH{1'b0}}, r_b};
    assign w_a_mag    = r_a;
    assign w_b_mag    = r_b;
    assign w_prod_fix = w_acc_nxt;
    assign w_quo_fix  = {{WIDTH{1'b0}}, w_q_nxt};
    assign w_rem_fix  = {{WIDTH{1'b0}}, w_rmd_nxt};
`endif

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_next = S_EXEC;
            S_EXEC: begin
                if (r_fct == F_MUL || (r_fct == F_DIV && r_b != '0)) w_next = S_ITER;
                else                                                 w_next = S_DONE;
            end
            S_ITER: if (r_cnt == CW'(1)) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (r_state == S_EXEC) || (r_state == S_ITER);
        done_o = (r_state == S_DONE);
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_a   <= '0;
            r_b   <= '0;
            r_fct <= '0;
            r_cnt <= '0;
            r_acc <= '0;
            r_mcd <= '0;
            r_q   <= '0;
            r_rmd <= '0;
            r_dvs <= '0;
            r_res <= '0;
            r_rem <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_a   <= a_i;
                        r_b   <= b_i;
                        r_fct <= fct_i;
                    end
                end
                S_EXEC: begin
                    r_err <= 1'b0;
                    case (r_fct)
                        F_ADD: begin
                            r_res <= w_a_ext + w_b_ext;
                            r_rem <= '0;
                        end
                        F_SUB: begin
                            r_res <= w_a_ext - w_b_ext;
                            r_rem <= '0;
                        end
                        F_MUL: begin
                            r_acc <= '0;
                            r_mcd <= {{WIDTH{1'b0}}, w_a_mag};
                            r_q   <= w_b_mag;
                            r_cnt <= CW'(WIDTH);
                        end
                        default: begin
                            if (r_b == '0) begin
                                r_res <= '0;
                                r_rem <= w_a_ext;
                                r_err <= 1'b1;
                            end else begin
                                r_rmd <= '0;
                                r_q   <= w_a_mag;
                                r_dvs <= w_b_mag;
                                r_cnt <= CW'(WIDTH);
                            end
                        end
                    endcase
                end
                S_ITER: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_fct == F_MUL) begin
                        r_acc <= w_acc_nxt;
                        r_mcd <= r_mcd << 1;
                        r_q   <= r_q >> 1;
                        if (r_cnt == CW'(1)) begin
                            r_res <= w_prod_fix;
                            r_rem <= '0;
                        end
                    end else begin
                        r_rmd <= w_rmd_nxt;
                        r_q   <= w_q_nxt;
                        if (r_cnt == CW'(1)) begin
                            r_res <= w_quo_fix;
                            r_rem <= w_rem_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_o = r_res;
    assign rem_o = r_rem;
    assign err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_calc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_calc_unit
// Purpose  : Scoreboard bench for seq_calc_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_calc_unit;

    localparam int W  = 8;
    localparam int W2 = 2 * W;
    localparam bit SIGNED_BUILD =
`ifdef SEQ_CALC_SIGNED_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        logic [W2-1:0] res;
        logic [W2-1:0] rem;
        logic          err;
        int            lat;
        int            sc;
    } exp_t;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic [1:0]    fct_i;
    logic          signed_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [W2-1:0] res_o;
    logic [W2-1:0] rem_o;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   dcnt  = 0;
    int   bcnt  = 0;
    int   total = 0;
    int   pass  = 0;

    seq_calc_unit #(.WIDTH(W)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .fct_i   (fct_i),
        .signed_i(signed_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .res_o   (res_o),
        .rem_o   (rem_o)
    );

    always #5 clock_i = ~clock_i;
    always @(posedge clock_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        else pass++;
    endtask

    // Plain integer arithmetic: SV '/' truncates toward zero, '%' follows the dividend
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] f, input logic s);
        exp_t   e;
        longint av, bv, r, q;
        logic   es;
        es    = s & SIGNED_BUILD;
        av    = es ? longint'($signed(a)) : longint'(a);
        bv    = es ? longint'($signed(b)) : longint'(b);
        r     = 0;
        q     = 0;
        e.err = 1'b0;
        e.lat = 2;
        e.sc  = 0;
        case (f)
            2'd0: r = av + bv;
            2'd1: r = av - bv;
            2'd2: begin r = av * bv; e.lat = W + 2; end
            default: begin
                if (bv == 0) begin
                    r = 0; q = av; e.err = 1'b1;
                end else begin
                    r = av / bv; q = av % bv; e.lat = W + 2;
                end
            end
        endcase
        e.res = r[W2-1:0];
        e.rem = q[W2-1:0];
        return e;
    endfunction

    always @(negedge clock_i) begin
        if (reset_i) begin
            if (busy_o) bcnt++;
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done: got done_o=1 expected no operation pending (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("res", 64'(res_o), 64'(mon_e.res));
                    chk("rem", 64'(rem_o), 64'(mon_e.rem));
                    chk("err", 64'(err_o), 64'(mon_e.err));
                    chk("latency", 64'(cyc - mon_e.sc + 1), 64'(mon_e.lat));
                    chk("busy_cycles", 64'(bcnt), 64'(mon_e.lat - 1));
                    chk("busy_low_at_done", 64'(busy_o), 64'd0);
                end
                bcnt = 0;
                dcnt++;
            end
        end
    end

    task automatic wait_done(input int tgt, input int poke);
        int k;
        k = 0;
        while (dcnt < tgt && k < 60) begin
            start_i = (k < poke);
            if (k < poke) begin
                a_i   = W'($urandom);
                b_i   = W'($urandom);
                fct_i = 2'($urandom);
            end
            @(negedge clock_i); #1;
            k++;
        end
        start_i = 1'b0;
        if (dcnt < tgt) begin
            total++;
            $display("FAIL done_timeout: got %0d completions expected %0d", dcnt, tgt);
            exp_q.delete();
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] f, input logic s, input int sc_off);
        exp_t e;
        e       = model(a, b, f, s);
        a_i     = a;
        b_i     = b;
        fct_i   = f;
        signed_i = s;
        start_i = 1'b1;
        e.sc    = cyc + sc_off;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] f, input logic s, input int poke);
        int tgt;
        tgt = dcnt + 1;
        @(negedge clock_i);
        drive(a, b, f, s, 1);
        @(negedge clock_i);
        start_i  = 1'b0;
        a_i      = W'($urandom);
        b_i      = W'($urandom);
        fct_i    = 2'($urandom);
        signed_i = 1'($urandom);
        wait_done(tgt, poke);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_res"},  64'(res_o),  64'd0);
        chk({tag, "_rem"},  64'(rem_o),  64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_err"},  64'(err_o),  64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0]   rf;
        int           tgt;

        reset_i  = 1'b0;
        start_i  = 1'b0;
        a_i      = '0;
        b_i      = '0;
        fct_i    = '0;
        signed_i = 1'b0;
        repeat (3) @(negedge clock_i);
        chk_all_zero("reset");
        reset_i = 1'b1;

        issue(8'd3,   8'd7,   2'd0, 1'b0, 0);
        issue(8'd3,   8'd7,   2'd1, 1'b0, 0);
        issue(8'd200, 8'd200, 2'd2, 1'b0, 4);
        repeat (3) @(negedge clock_i);
        chk("res_hold_after_pokes", 64'(res_o), 64'h9C40);
        chk("no_extra_done", 64'(exp_q.size()), 64'd0);
        issue(8'd100, 8'd7,   2'd3, 1'b0, 0);
        issue(8'd9,   8'd0,   2'd3, 1'b0, 0);
        issue(8'd10,  8'd1,   2'd0, 1'b0, 0);
        issue(8'hF9,  8'd3,   2'd2, 1'b1, 0);
        issue(8'hF9,  8'd2,   2'd3, 1'b1, 0);
        issue(8'h80,  8'hFF,  2'd3, 1'b1, 0);
        issue(8'h85,  8'd0,   2'd3, 1'b1, 0);
        issue(8'h80,  8'h7F,  2'd1, 1'b1, 0);

        // A start held through DONE must be taken only in the following IDLE cycle
        tgt = dcnt + 2;
        @(negedge clock_i);
        drive(8'd20, 8'd5, 2'd0, 1'b0, 1);
        @(negedge clock_i);
        start_i = 1'b0;
        @(negedge clock_i);
        drive(8'd20, 8'd50, 2'd1, 1'b0, 2);
        @(negedge clock_i);
        @(negedge clock_i);
        start_i = 1'b0;
        wait_done(tgt, 0);

        // Asynchronous reset in the middle of a multiply
        @(negedge clock_i);
        drive(8'd77, 8'd91, 2'd2, 1'b0, 1);
        @(negedge clock_i);
        start_i = 1'b0;
        repeat (3) @(negedge clock_i);
        #2 reset_i = 1'b0;
        #1;
        exp_q.delete();
        bcnt = 0;
        chk_all_zero("midreset");
        @(negedge clock_i);
        reset_i = 1'b1;
        issue(8'd13, 8'd11, 2'd2, 1'b0, 0);

        for (int n = 0; n < 60; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rf = 2'($urandom);
            if ($urandom_range(0, 5) == 0) ra = 8'h80;
            issue(ra, rb, rf, 1'($urandom), (rf == 2'd2) ? $urandom_range(0, 4) : 0);
        end

        repeat (4) @(negedge clock_i);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
`default_nettype wire
